rng_arbiter: RTL

Shares the single `rand_num_gen` instance between several requesters, for example the game FSM and the VGA card-flip animation. Requests are arbitrated round-robin. The block owns the RNG `enable` line: it stirs the generator for a fixed number of cycles per transaction, then returns one registered 8-bit value to the granted requester with a one-cycle valid pulse. It sits between the requesters and `rand_num_gen`, replacing direct `enable` drive by the game FSM.

---
 rtl/hol_pkg.sv | 25 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rng_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/hol_pkg.sv
// Shared constants and encodings for the game datapath: RNG width, arbiter
// state encoding, and LED/state constants used by the game FSM.
package hol_pkg;

  localparam int RAND_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STIR    = 2'd1,
    DELIVER = 2'd2
  } rng_arb_state_t;

  localparam int          LED_W    = 8;
  localparam logic [7:0]  LED_OFF  = 8'h00;
  localparam logic [7:0]  LED_WIN  = 8'hFF;
  localparam logic [7:0]  LED_LOSE = 8'h0F;
  localparam logic [7:0]  LED_TIE  = 8'h3C;

  localparam logic [2:0]  GAME_ST_IDLE   = 3'd0;
  localparam logic [2:0]  GAME_ST_DEAL   = 3'd1;
  localparam logic [2:0]  GAME_ST_GUESS  = 3'd2;
  localparam logic [2:0]  GAME_ST_REVEAL = 3'd3;
  localparam logic [2:0]  GAME_ST_RESULT = 3'd4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after last_idx, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_idx,
  output logic [NUM_REQ-1:0] win,
  output logic [IW-1:0]      win_idx,
  output logic               any
);

  logic [IW:0] pos;

  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    pos     = '0;
    // Offsets 1..NUM_REQ visit every requester once, ending on last_idx itself.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      pos = {1'b0, last_idx} + (IW+1)'(i);
      if (pos >= (IW+1)'(NUM_REQ))
        pos = pos - (IW+1)'(NUM_REQ);
      if (!any && req[pos[IW-1:0]]) begin
        any                 = 1'b1;
        win[pos[IW-1:0]]    = 1'b1;
        win_idx             = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one rand_num_gen: stirs the RNG a fixed number
// of cycles per grant, then delivers one registered value with a valid pulse.
module rng_arbiter
  import hol_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int STIR_CYCLES   = 4,
  parameter int IDLE_FREE_RUN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [RAND_W-1:0]  rand_out,
  output logic               rand_valid,
  output logic               busy,
  output logic               rng_enb,
  input  logic [RAND_W-1:0]  rng_rand
);

  localparam int CW = $clog2(STIR_CYCLES + 1);
  localparam int IW = $clog2(NUM_REQ);

  rng_arb_state_t      state;
  logic [CW-1:0]       stir_cnt;
  logic [IW-1:0]       last_idx;
  logic [IW-1:0]       cur_idx;
  logic [NUM_REQ-1:0]  win;
  logic [IW-1:0]       win_idx;
  logic                any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req      (req),
    .last_idx (last_idx),
    .win      (win),
    .win_idx  (win_idx),
    .any      (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      rand_out   <= '0;
      rand_valid <= 1'b0;
      stir_cnt   <= '0;
      last_idx   <= IW'(NUM_REQ - 1);
      cur_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            gnt      <= win;
            cur_idx  <= win_idx;
            stir_cnt <= CW'(STIR_CYCLES - 1);
            state    <= STIR;
          end
        end
        STIR: begin
          if (stir_cnt != '0) begin
            stir_cnt <= stir_cnt - 1'b1;
          end else begin
            rand_out   <= rng_rand;
            rand_valid <= 1'b1;
            state      <= DELIVER;
          end
        end
        DELIVER: begin
          gnt        <= '0;
          rand_valid <= 1'b0;
          last_idx   <= cur_idx;
          state      <= IDLE;
        end
        default: begin
          gnt        <= '0;
          rand_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rng_enb = 1'b0;
    case (state)
      IDLE:    rng_enb = (IDLE_FREE_RUN != 0);
      STIR:    rng_enb = 1'b1;
      default: rng_enb = 1'b0;
    endcase
  end

  assign busy = (state != IDLE);

endmodule
